// File: rtl/cpu_mem_ctrl.sv
// Loader and run sequencer for a small CPU: streams a byte image into data RAM
// and instruction ROM, then walks the CPU through reset, setup and run phases.
module cpu_mem_ctrl #(
  parameter int unsigned PMSB = 7,
  parameter int unsigned AMSB = 7,
  parameter int unsigned DMSB = 7
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [7:0]      ld_data,
  input  logic            start,
  input  logic [PMSB:0]   pc,
  output logic [15:0]     inst,
  input  logic [AMSB:0]   addr,
  input  logic [DMSB:0]   wdata,
  input  logic            write,
  input  logic            idle,
  output logic [DMSB:0]   rdata,
  output logic            cpu_rstn,
  output logic            cpu_setn,
  output logic            busy,
  output logic            done,
  output logic [15:0]     cycles
);

  localparam int unsigned PW        = PMSB + 1;
  localparam int unsigned AW        = AMSB + 1;
  localparam int unsigned DW        = DMSB + 1;
  localparam int unsigned RAM_DEPTH = 1 << AW;
  localparam int unsigned ROM_DEPTH = 1 << PW;

  typedef enum logic [2:0] {
    IDLE, LOAD_RAM, LOAD_ROM, RST_HOLD, SET_HOLD, RUN, DONE
  } state_t;

  state_t          state, state_nxt;
  logic            hold_cnt;
  logic [AW-1:0]   ram_ptr;
  logic [PW-1:0]   rom_ptr;
  logic            lo_phase;
  logic [7:0]      hi_byte;
  logic            rom_valid;

  logic            accept;
  logic            ram_we;
  logic [AW-1:0]   ram_wa;
  logic [DW-1:0]   ram_wd;
  logic            rom_we;

  logic [DW-1:0]   ram [RAM_DEPTH];
  logic [15:0]     rom [ROM_DEPTH];

  assign accept = ld_valid & ld_ready;

  // Next state and memory write steering
  always_comb begin
    state_nxt = state;
    ram_we    = 1'b0;
    ram_wa    = ram_ptr;
    ram_wd    = DW'(ld_data);
    rom_we    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          ram_we    = 1'b1;
          ram_wa    = '0;
          state_nxt = LOAD_RAM;
        end else if (start && rom_valid) begin
          state_nxt = RST_HOLD;
        end
      end
      LOAD_RAM: begin
        if (accept) begin
          ram_we = 1'b1;
          if (&ram_ptr) state_nxt = LOAD_ROM;
        end
      end
      LOAD_ROM: begin
        if (accept && lo_phase) begin
          rom_we = 1'b1;
          if (&rom_ptr) state_nxt = RST_HOLD;
        end
      end
      RST_HOLD: if (hold_cnt) state_nxt = SET_HOLD;
      SET_HOLD: if (hold_cnt) state_nxt = RUN;
      RUN: begin
        if (write) begin
          ram_we = 1'b1;
          ram_wa = addr;
          ram_wd = wdata;
        end
        if (idle) state_nxt = DONE;
      end
      DONE:    if (start) state_nxt = RST_HOLD;
      default: state_nxt = IDLE;
    endcase
  end

  // State, pointers and registered status outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      hold_cnt  <= 1'b0;
      ram_ptr   <= '0;
      rom_ptr   <= '0;
      lo_phase  <= 1'b0;
      hi_byte   <= '0;
      rom_valid <= 1'b0;
      cycles    <= '0;
      ld_ready  <= 1'b1;
      cpu_rstn  <= 1'b0;
      cpu_setn  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= (state_nxt == state) ? ~hold_cnt : 1'b0;

      if (state == IDLE && accept) begin
        ram_ptr   <= AW'(1);
        rom_ptr   <= '0;
        lo_phase  <= 1'b0;
        rom_valid <= 1'b0;
      end else if (state == LOAD_RAM && accept) begin
        ram_ptr <= ram_ptr + AW'(1);
      end

      if (state == LOAD_ROM && accept) begin
        lo_phase <= ~lo_phase;
        if (!lo_phase) hi_byte <= ld_data;
        else           rom_ptr <= rom_ptr + PW'(1);
      end

      if (state == LOAD_ROM && state_nxt == RST_HOLD) rom_valid <= 1'b1;

      // Run counter restarts on every SET_HOLD entry and sticks at all-ones
      if (state != SET_HOLD && state_nxt == SET_HOLD) cycles <= '0;
      else if (state == RUN && cycles != 16'hFFFF)  cycles <= cycles + 16'd1;

      ld_ready <= (state_nxt inside {IDLE, LOAD_RAM, LOAD_ROM});
      cpu_rstn <= (state_nxt inside {SET_HOLD, RUN});
      cpu_setn <= (state_nxt == RUN);
      busy     <= !(state_nxt inside {IDLE, DONE});
      done     <= (state_nxt == DONE);
    end
  end

  // Memory arrays hold their contents across reset
  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_wa] <= ram_wd;
    if (rom_we) rom[rom_ptr] <= {hi_byte, ld_data};
  end

  assign inst  = rom[pc];
  assign rdata = ram[addr];

endmodule

// File: tb/tb_cpu_mem_ctrl.sv
// Directed bench for cpu_mem_ctrl: loads images, sequences runs and checks
// handshake, hold timing, cycle counting and memory contents.
module tb_cpu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        ld_valid;
  logic        ld_ready;
  logic [7:0]  ld_data;
  logic        start;
  logic [7:0]  pc;
  logic [15:0] inst;
  logic [7:0]  addr;
  logic [7:0]  wdata;
  logic        write;
  logic        idle;
  logic [7:0]  rdata;
  logic        cpu_rstn;
  logic        cpu_setn;
  logic        busy;
  logic        done;
  logic [15:0] cycles;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  cpu_mem_ctrl dut (
    .clk(clk), .rstn(rstn), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_data(ld_data), .start(start), .pc(pc), .inst(inst), .addr(addr),
    .wdata(wdata), .write(write), .idle(idle), .rdata(rdata),
    .cpu_rstn(cpu_rstn), .cpu_setn(cpu_setn), .busy(busy), .done(done),
    .cycles(cycles)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input bit stall);
    if (stall && $urandom_range(0, 1) == 1) begin
      ld_valid = 1'b0;
      step();
    end
    ld_valid = 1'b1;
    ld_data  = b;
    step();
  endtask

  // pat=0: RAM all A5, ROM all 0000; pat=1: RAM i^5A, ROM {j,~j}
  task automatic load_all(input bit pat, input bit stall, input bit start_first, input bit start_rom);
    logic [7:0]  b;
    logic [15:0] w;
    for (int i = 0; i < 256; i++) begin
      b = pat ? (8'(i) ^ 8'h5A) : 8'hA5;
      start = start_first && (i == 0);
      send(b, stall);
      start = 1'b0;
      if (start_first && i == 0) begin
        addr = 8'h00;
        #1;
        chk("first_byte_ready", 32'(ld_ready), 32'd1);
        chk("first_byte_busy", 32'(busy), 32'd1);
        chk("first_byte_ram0", 32'(rdata), 32'h5A);
      end
    end
    for (int j = 0; j < 256; j++) begin
      w = pat ? {8'(j), ~8'(j)} : 16'h0000;
      start = start_rom && (j == 10);
      send(w[15:8], stall);
      start = 1'b0;
      if (start_rom && j == 10) begin
        chk("rom_start_busy", 32'(busy), 32'd1);
        chk("rom_start_ready", 32'(ld_ready), 32'd1);
      end
      send(w[7:0], stall);
    end
    ld_valid = 1'b0;
    chk("ready_drop_rst_hold", 32'(ld_ready), 32'd0);
  endtask

  // Called right after the edge that enters RST_HOLD; returns after entering RUN
  task automatic hold_seq();
    for (int k = 0; k < 2; k++) begin
      chk("rst_hold_rstn", 32'(cpu_rstn), 32'd0);
      chk("rst_hold_setn", 32'(cpu_setn), 32'd0);
      chk("rst_hold_busy", 32'(busy), 32'd1);
      step();
    end
    for (int k = 0; k < 2; k++) begin
      chk("set_hold_rstn", 32'(cpu_rstn), 32'd1);
      chk("set_hold_setn", 32'(cpu_setn), 32'd0);
      chk("set_hold_cycles", 32'(cycles), 32'd0);
      step();
    end
    chk("run_rstn", 32'(cpu_rstn), 32'd1);
    chk("run_setn", 32'(cpu_setn), 32'd1);
    chk("run_cycles", 32'(cycles), 32'd0);
  endtask

  task automatic finish_run(input logic [15:0] exp_cycles);
    idle = 1'b1;
    step();
    idle = 1'b0;
    chk("done_flag", 32'(done), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_rstn", 32'(cpu_rstn), 32'd0);
    chk("done_setn", 32'(cpu_setn), 32'd0);
    chk("done_cycles", 32'(cycles), 32'(exp_cycles));
  endtask

  initial begin
    rstn = 1'b0; ld_valid = 1'b0; ld_data = '0; start = 1'b0;
    pc = '0; addr = '0; wdata = '0; write = 1'b0; idle = 1'b0;
    repeat (3) step();
    chk("rst_ready", 32'(ld_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cpu_rstn", 32'(cpu_rstn), 32'd0);
    chk("rst_cpu_setn", 32'(cpu_setn), 32'd0);
    chk("rst_cycles", 32'(cycles), 32'd0);
    rstn = 1'b1;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_no_rom_ignored", 32'(busy), 32'd0);

    // Continuous load of a flat image, idle on first RUN cycle
    load_all(1'b0, 1'b0, 1'b0, 1'b0);
    hold_seq();
    finish_run(16'd1);
    addr = 8'h00; pc = 8'h00; #1;
    chk("img0_ram00", 32'(rdata), 32'hA5);
    chk("img0_rom00", 32'(inst), 32'h0000);
    addr = 8'hFF; pc = 8'hFF; #1;
    chk("img0_ramff", 32'(rdata), 32'hA5);
    chk("img0_romff", 32'(inst), 32'h0000);

    // Reload a patterned image with random stalls and stray starts
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    step();
    load_all(1'b1, 1'b1, 1'b1, 1'b1);
    hold_seq();
    addr = 8'h10; wdata = 8'h3C; write = 1'b1; start = 1'b1;
    #1;
    chk("same_cycle_old_data", 32'(rdata), 32'h4A);
    step();
    write = 1'b0; start = 1'b0;
    chk("run_start_ignored", 32'(cpu_setn), 32'd1);
    chk("write_landed", 32'(rdata), 32'h3C);
    chk("run_cycles_1", 32'(cycles), 32'd1);
    finish_run(16'd2);
    addr = 8'h20; pc = 8'h03; #1;
    chk("img1_ram20", 32'(rdata), 32'h7A);
    chk("img1_rom03", 32'(inst), 32'h03FC);
    addr = 8'hFF; pc = 8'hFF; #1;
    chk("img1_ramff", 32'(rdata), 32'hA5);
    chk("img1_romff", 32'(inst), 32'hFF00);

    // Writes outside RUN must be dropped
    addr = 8'h10; wdata = 8'h00; write = 1'b1;
    step();
    write = 1'b0;
    chk("no_write_in_done", 32'(rdata), 32'h3C);

    // Re-run from DONE without reload
    start = 1'b1;
    step();
    start = 1'b0;
    chk("rerun_busy", 32'(busy), 32'd1);
    chk("rerun_ready", 32'(ld_ready), 32'd0);
    chk("rerun_done_clr", 32'(done), 32'd0);
    hold_seq();
    finish_run(16'd1);
    chk("rerun_ram10", 32'(rdata), 32'h3C);

    // Long run to saturate the counter, then reset mid-run
    start = 1'b1;
    step();
    start = 1'b0;
    hold_seq();
    repeat (70000) step();
    chk("cycles_saturated", 32'(cycles), 32'hFFFF);
    chk("still_running", 32'(cpu_setn), 32'd1);
    rstn = 1'b0;
    #1;
    chk("abort_cpu_rstn", 32'(cpu_rstn), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_cycles", 32'(cycles), 32'd0);
    chk("abort_ready", 32'(ld_ready), 32'd1);
    step();
    rstn = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_after_abort_ignored", 32'(busy), 32'd0);
    load_all(1'b0, 1'b0, 1'b0, 1'b0);
    hold_seq();
    finish_run(16'd1);
    addr = 8'h10; #1;
    chk("reload_ram10", 32'(rdata), 32'hA5);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cpu_mem_ctrl.md
CPU_MEM_CTRL -- requirements
Module: cpu_mem_ctrl

Interface
REQ-001 Parameters: PMSB, default 7, pc MSB; ROM depth 2^(PMSB+1) words of 16 bits.
REQ-002 Parameters: AMSB, default 7, addr MSB; RAM depth 2^(AMSB+1) bytes.
REQ-003 Parameters: DMSB, default 7, data MSB; fixed at 7, byte RAM.
REQ-004 clk  in  1  clock; all state updates on posedge.
REQ-005 rstn  in  1  reset, asynchronous, active-low.
REQ-006 ld_valid  in  1  load byte strobe; ld_ready  out  1  byte accepted this cycle when both high.
REQ-007 ld_data  in  8  load byte stream.
REQ-008 start  in  1  single-cycle pulse; re-runs the loaded program without reloading.
REQ-009 pc  in  PMSB+1  CPU program counter; inst  out  16  instruction word for pc.
REQ-010 addr  in  AMSB+1, wdata  in  DMSB+1, write  in  1  CPU data-memory request.
REQ-011 idle  in  1  CPU halt indication.
REQ-012 rdata  out  DMSB+1  RAM read data for addr.
REQ-013 cpu_rstn  out  1  CPU reset, active-low; cpu_setn  out  1  CPU run enable.
REQ-014 busy  out  1  load or run in progress; done  out  1  program has halted.
REQ-015 cycles  out  16  CPU run cycle count of last or current run.

Function
REQ-016 States SHALL be IDLE, LOAD_RAM, LOAD_ROM, RST_HOLD, SET_HOLD, RUN, DONE.
REQ-017 ld_ready SHALL be 1 only in IDLE, LOAD_RAM and LOAD_ROM.
REQ-018 IDLE: accepted byte SHALL be written to ram[0] and move to LOAD_RAM with ram pointer 1.
REQ-019 LOAD_RAM: each accepted byte SHALL be written to ram[ptr], ptr+1; after byte 2^(AMSB+1)-1, go to LOAD_ROM with ptr 0.
REQ-020 LOAD_ROM: two bytes per word, high byte first; low byte SHALL complete rom[ptr] = {hi,lo}; after word 2^(PMSB+1)-1, go to RST_HOLD.
REQ-021 Cycles without ld_valid SHALL not advance load pointers (stalls allowed anywhere).
REQ-022 RST_HOLD: cpu_rstn=0, cpu_setn=0 for exactly 2 cycles, then SET_HOLD.
REQ-023 SET_HOLD: cpu_rstn=1, cpu_setn=0 for exactly 2 cycles, then RUN; cycles cleared to 0 on entry.
REQ-024 RUN: cpu_rstn=1, cpu_setn=1; cycles +1 per clock, saturating at 16'hFFFF.
REQ-025 RUN: when idle=1 at a posedge, go to DONE; that cycle is counted.
REQ-026 DONE: done=1, cpu_rstn=0, cpu_setn=0; RAM contents retained.
REQ-027 start in IDLE (with ROM valid) or DONE SHALL go to RST_HOLD; start ignored in other states.
REQ-028 start and accepted ld byte in the same IDLE cycle: load SHALL take priority and start is dropped.
REQ-029 inst SHALL be rom[pc], combinational; rdata SHALL be ram[addr], combinational.
REQ-030 In RUN, write=1 SHALL store wdata into ram[addr] at the posedge; no write outside RUN.
REQ-031 Same-cycle read and write to one address: rdata shows old data until the posedge.
REQ-032 busy SHALL be 1 in all states except IDLE and DONE.
REQ-033 After a completed load, a ROM-valid flag SHALL be set; start in IDLE without it is ignored.

Reset
REQ-034 rstn low SHALL force IDLE, cpu_rstn=0, cpu_setn=0, done=0, busy=0, cycles=0, pointers 0, ROM-valid 0.
REQ-035 RAM/ROM contents are not reset; reset mid-load or mid-run aborts and requires a full reload.

Verification
REQ-036 Load 256 bytes 8'hA5 then 256 words 16'h0000 -> ROM words read back 0; RST_HOLD 2 cycles, SET_HOLD 2 cycles, idle=1 first RUN cycle -> done, cycles=1.
REQ-037 ld_valid toggled 50% random during load -> identical memory image as continuous load; ld_ready drops on entering RST_HOLD.
REQ-038 Program stores 8'h3C to addr 8'h10 (write=1) then halts -> ram[8'h10]=8'h3C, rdata=8'h3C when addr=8'h10.
REQ-039 Run to DONE, then start pulse -> second run with no reload, cycles recounted from 0, same result.
REQ-040 rstn pulsed low during RUN -> immediate IDLE, cpu_rstn=0; start ignored until full 768-byte reload.
REQ-041 start asserted during LOAD_ROM and RUN -> no effect; idle held 0 for 70000 cycles -> cycles saturates at 16'hFFFF.
